// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline control blocks.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents: md_state_t (MD unit FSM states), default MD occupancy constants,
// reg_match() helper that compares a producer destination against D's sources.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True when the producer writes a register that D actually reads.
  // $zero is never a real dependency.
  function automatic logic reg_match(
    input logic [4:0] wr,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    return (wr != 5'd0) && ((use_rs && (rs == wr)) || (use_rt && (rt == wr)));
  endfunction

endpackage

// File: rtl/md_timer.sv
// Occupancy tracker for the multi-cycle mult/div unit (FSM + down-counter).
// Latency: md_busy rises the cycle after md_start_E and stays high N-1 cycles.
// Backpressure: none; a start while BUSY is ignored (D stalls any MD op then).
//
// Ports:
//   clk, rst    core clock, synchronous active-high reset
//   md_start_E  mult/div in E this cycle
//   md_div_E    1 = div, 0 = mult (qualifies md_start_E)
//   md_busy     registered busy flag
module md_timer
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_E,
  input  logic md_div_E,
  output logic md_busy
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  if (MULT_CYCLES < 2 || DIV_CYCLES < 2 || MULT_CYCLES > DIV_CYCLES) begin : g_bad_cycles
    $error("md_timer: need 2 <= MULT_CYCLES <= DIV_CYCLES");
  end

  // The E cycle is the first occupied cycle and the cnt==0 cycle the last,
  // so the reload value is N-2.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start_E) begin
          cnt_d   = md_div_E ? DIV_LOAD : MULT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: straight from the state flop, so md_busy is registered.
  always_comb begin
    md_busy = (state_q == BUSY);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, branch-operand and MD hazards.
// Latency: stall outputs are combinational, same cycle as the hazard.
// Backpressure: a stall holds F and D and injects a bubble into E.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   rs_D, rt_D, use_rs_D, use_rt_D source operands of the D instruction
//   branch_D, md_use_D             D instruction is a branch / an MD op
//   wr_E, regwr_E, memrd_E         destination info of the E instruction
//   wr_M, memrd_M                  destination info of the M instruction
//   md_start_E, md_div_E           mult/div entering the MD unit
//   stop_F, stop_D, flush_E        hold PC, hold D, bubble E
//   md_busy                        MD unit busy (registered)
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       use_rs_D,
  input  logic       use_rt_D,
  input  logic       branch_D,
  input  logic       md_use_D,
  input  logic [4:0] wr_E,
  input  logic       regwr_E,
  input  logic       memrd_E,
  input  logic [4:0] wr_M,
  input  logic       memrd_M,
  input  logic       md_start_E,
  input  logic       md_div_E,
  output logic       stop_F,
  output logic       stop_D,
  output logic       flush_E,
  output logic       md_busy
);

  logic m_e, m_m, stall;

  md_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk       (clk),
    .rst       (rst),
    .md_start_E(md_start_E),
    .md_div_E  (md_div_E),
    .md_busy   (md_busy)
  );

  always_comb begin
    m_e = reg_match(wr_E, rs_D, rt_D, use_rs_D, use_rt_D);
    m_m = reg_match(wr_M, rs_D, rt_D, use_rs_D, use_rt_D);

    // Branches compare in D, so even an ALU result in E is too late for them;
    // non-branch consumers get ALU results by forwarding and are not stalled.
    // md_start_E covers the cycle before md_busy rises.
    stall = (memrd_E && m_e)
          | (branch_D && regwr_E && m_e)
          | (branch_D && memrd_M && m_m)
          | (md_use_D && (md_busy || md_start_E));

    stop_F  = stall && !rst;
    stop_D  = stall && !rst;
    flush_E = stall && !rst;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_D, rt_D, wr_E, wr_M;
  logic       use_rs_D, use_rt_D, branch_D, md_use_D;
  logic       regwr_E, memrd_E, memrd_M, md_start_E, md_div_E;
  logic       stop_F, stop_D, flush_E, md_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .use_rs_D  (use_rs_D),
    .use_rt_D  (use_rt_D),
    .branch_D  (branch_D),
    .md_use_D  (md_use_D),
    .wr_E      (wr_E),
    .regwr_E   (regwr_E),
    .memrd_E   (memrd_E),
    .wr_M      (wr_M),
    .memrd_M   (memrd_M),
    .md_start_E(md_start_E),
    .md_div_E  (md_div_E),
    .stop_F    (stop_F),
    .stop_D    (stop_D),
    .flush_E   (flush_E),
    .md_busy   (md_busy)
  );

  task automatic clr();
    rs_D = 5'd0; rt_D = 5'd0; wr_E = 5'd0; wr_M = 5'd0;
    use_rs_D = 1'b0; use_rt_D = 1'b0; branch_D = 1'b0; md_use_D = 1'b0;
    regwr_E = 1'b0; memrd_E = 1'b0; memrd_M = 1'b0;
    md_start_E = 1'b0; md_div_E = 1'b0;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample on the falling edge; exp = {stop_F, stop_D, flush_E, md_busy}.
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    @(negedge clk);
    obs = {stop_F, stop_D, flush_E, md_busy};
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    cyc();
    cyc();

    // Reset forces stall outputs low even with a live load-use hazard.
    memrd_E = 1'b1; regwr_E = 1'b1; wr_E = 5'd3; use_rs_D = 1'b1; rs_D = 5'd3;
    chk("reset_forced", 4'b0000);
    cyc();
    rst = 1'b0;

    // 1. lw $3 in E, add reads $3 in D: one stall cycle.
    chk("t1_load_use", 4'b1110);
    cyc();
    memrd_E = 1'b0; regwr_E = 1'b0; wr_E = 5'd0; memrd_M = 1'b1; wr_M = 5'd3;
    chk("t1_released", 4'b0000);

    // 2. $zero never stalls; rt only matters when read.
    cyc(); clr();
    memrd_E = 1'b1; regwr_E = 1'b1; wr_E = 5'd0; use_rs_D = 1'b1; rs_D = 5'd0;
    chk("t2_zero_reg", 4'b0000);
    cyc();
    wr_E = 5'd7; rt_D = 5'd7; use_rs_D = 1'b0; use_rt_D = 1'b0;
    chk("t2_rt_unused", 4'b0000);
    cyc();
    use_rt_D = 1'b1;
    chk("t2_rt_used", 4'b1110);

    // Non-branch consumer of an ALU result in E is forwarded, not stalled.
    cyc(); clr();
    regwr_E = 1'b1; wr_E = 5'd5; use_rt_D = 1'b1; rt_D = 5'd5;
    chk("t2_alu_fwd", 4'b0000);

    // 3. beq reading $5: ALU producer in E, then load producer in M.
    cyc();
    branch_D = 1'b1;
    chk("t3_branch_alu", 4'b1110);
    cyc();
    regwr_E = 1'b0; wr_E = 5'd0; memrd_M = 1'b1; wr_M = 5'd5;
    chk("t3_branch_ld", 4'b1110);
    cyc();
    memrd_M = 1'b0;
    chk("t3_branch_alu_in_m", 4'b0000);

    // 4. mult in E with mflo in D: 5 stall cycles, md_busy for the last 4.
    cyc(); clr();
    md_start_E = 1'b1; md_div_E = 1'b0; md_use_D = 1'b1;
    chk("t4_start_stall", 4'b1110);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      md_start_E = 1'b0;
      chk($sformatf("t4_busy_%0d", k), 4'b1111);
    end
    cyc();
    chk("t4_released", 4'b0000);
    cyc();
    chk("t4_idle", 4'b0000);

    // 5. div, reset on the 3rd BUSY cycle aborts the count.
    cyc(); clr();
    md_start_E = 1'b1; md_div_E = 1'b1;
    chk("t5_start", 4'b0000);
    cyc();
    md_start_E = 1'b0; md_div_E = 1'b0;
    chk("t5_busy_1", 4'b0001);
    cyc();
    chk("t5_busy_2", 4'b0001);
    cyc();
    rst = 1'b1; md_use_D = 1'b1;
    chk("t5_busy_3_rst", 4'b0001);
    cyc();
    rst = 1'b0;
    chk("t5_aborted", 4'b0000);

    // 6. Hazard-free non-MD op during a div: no stall, full 9-cycle busy.
    cyc(); clr();
    md_start_E = 1'b1; md_div_E = 1'b1;
    chk("t6_start", 4'b0000);
    cyc();
    md_start_E = 1'b0; md_div_E = 1'b0;
    use_rs_D = 1'b1; rs_D = 5'd4; regwr_E = 1'b1; wr_E = 5'd9;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("t6_busy_%0d", k), 4'b0001);
      cyc();
    end
    chk("t6_released", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
